// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter_if
// Bundles the producer-side and consumer-side signals of the 8-lane
// round-robin byte arbiter.
//   req       : per-lane request, lane i valid while req[i] is high
//   in_data   : eight lane bytes, lane i = in_data[8i+7:8i]
//   gnt       : one-hot grant, lane i's byte is captured at this edge
//   out_valid : output register holds a byte
//   out_data  : captured byte
//   out_src   : lane index of out_data
//   out_ready : consumer accepts out_data when out_valid && out_ready
// The master modport is the environment (producers + consumer); the slave
// modport is the arbiter itself.
interface mux8_rr_arbiter_if;
  logic [7:0]  req;
  logic [63:0] in_data;
  logic [7:0]  gnt;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_src;
  logic        out_ready;

  modport master (
    output req, in_data, out_ready,
    input  gnt, out_valid, out_data, out_src
  );

  modport slave (
    input  req, in_data, out_ready,
    output gnt, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
// Round-robin arbiter plus a one-entry registered output stage that shares an
// 8-to-1 byte select path among eight requesters. A winner may keep the path
// for up to BURST consecutive grants before priority rotates past it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux8_rr_arbiter_if.slave (req/in_data/gnt producer side,
//           out_valid/out_data/out_src/out_ready consumer side)
// Parameters:
//   BURST : maximum consecutive grants to one lane, legal range 1..15
module mux8_rr_arbiter #(
  parameter int unsigned BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mux8_rr_arbiter_if.slave    bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] src_q, src_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] own_q, own_d;
  logic [3:0] cnt_q, cnt_d;

  logic       load_en;
  logic       found;
  logic       grant;
  logic [2:0] sel;
  logic [3:0] cnt_inc;
  logic       burst_done;

  // Winner search: first requesting lane starting at ptr and wrapping.
  // The 3-bit index sum wraps modulo 8 on its own.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < 8; i++) begin
      if (!found && bus.req[ptr_q + 3'(i)]) begin
        found = 1'b1;
        sel   = ptr_q + 3'(i);
      end
    end
  end

  // A new byte may enter when the register is empty or is draining this
  // cycle. Reset gates the grant so gnt drops immediately on rst_n low.
  assign load_en = (state_q == EMPTY) || bus.out_ready;
  assign grant   = rst_n && load_en && found;

  // Burst bookkeeping: consecutive grants to the same owner count up; the
  // count restarts at 1 whenever ownership changes.
  assign cnt_inc    = (sel == own_q) ? cnt_q + 4'd1 : 4'd1;
  assign burst_done = (cnt_inc == 4'(BURST));

  // Next-state logic for the output register, pointer and burst counter.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    if (grant) begin
      state_d = FULL;
      data_d  = bus.in_data[{sel, 3'b000} +: 8];
      src_d   = sel;
      own_d   = sel;
      if (burst_done) begin
        // Burst exhausted: rotate priority past the winner.
        ptr_d = sel + 3'd1;
        cnt_d = '0;
      end else begin
        // Winner keeps priority while it continues to request.
        ptr_d = sel;
        cnt_d = cnt_inc;
      end
    end else if ((state_q == FULL) && bus.out_ready) begin
      // Drained with nothing to replace it; data/src keep their last value.
      state_d = EMPTY;
    end
  end

  // State and output registers; reset discards any in-flight byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt       = grant ? (8'd1 << sel) : 8'd0;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and output stage that shares the 8-lane, 8-bit, 8-to-1 select datapath among eight requesters. Each cycle it picks one requesting lane, drives the internal 3-bit select, and captures the selected byte into a registered output with a valid/ready handshake. A configurable burst limit lets a winner keep the path for several consecutive transfers before priority rotates. It sits between the eight producer lanes and the single downstream byte consumer.

## Interface
- BURST, default 4: maximum consecutive grants to one lane before priority rotates; legal range 1..15.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  8  per-lane request; req[i] is high while lane i presents a valid byte.
- in_data  in  64  lane bytes; lane i = in_data[8i+7:8i].
- gnt  out  8  one-hot, combinational, one cycle; gnt[i] = lane i's byte is captured at this edge; the producer advances on gnt.
- out_valid  out  1  output register holds a byte.
- out_data  out  8  captured byte.
- out_src  out  3  lane index of out_data.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.

## Operation
- Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = (EMPTY) or (FULL and out_ready). A grant occurs only when load_en and |req.
- Winner: first set bit of req scanning ptr, ptr+1, ..., ptr+7 modulo 8. sel = winner index; the selected byte is in_data lane sel.
- On grant: out_data <= lane sel, out_src <= sel, out_valid <= 1, gnt[sel]=1 in that cycle.
- FULL and out_ready with no req: out_valid <= 0 (-> EMPTY); out_data/out_src hold their last value.
- FULL and !out_ready: all registers hold; gnt = 0; req changes are ignored.
- Burst counter cnt (4 bits) and last owner own:
  - grant to sel == own: cnt <= cnt+1; otherwise cnt <= 1, own <= sel.
  - if the new cnt value == BURST: ptr <= (sel+1) mod 8, cnt <= 0.
  - else ptr <= sel (sel keeps priority if it still requests).
- BURST=1 gives pure round-robin: ptr always advances past the winner.
- No grant: ptr, cnt and own hold.
- Reset (async, any time): out_valid=0, out_data=0, out_src=0, gnt=0, ptr=0, cnt=0, own=0; an in-flight byte is discarded. Outputs are well-defined on the first edge after rst_n releases.

## Timing
- Request-to-output latency: 1 cycle. A req seen at edge N with load_en gives gnt high before edge N, and out_valid/out_data are valid after edge N.
- Throughput: 1 byte/cycle while out_ready stays high (simultaneous drain and load).
- gnt depends combinationally on req, ptr, state and out_ready. There is no combinational path from in_data to any output.
- Starvation bound: with BURST=B, a continuously requesting lane is granted within 7*B grants.
- req may drop at any time before a grant without side effects. A lane whose req drops mid-burst loses its remaining burst credit at the next grant to another lane.

## Test plan
- Reset: assert rst_n=0 mid-transfer with out_valid=1 -> out_valid=0, out_data=0, out_src=0 and gnt=0 immediately. After release with req=0x00, all stay 0.
- Single lane: req=0x08, in_data lane3=0xA5, out_ready=1 -> gnt=0x08, next cycle out_valid=1, out_data=0xA5, out_src=3.
- Pure round-robin, BURST=1: req=0xFF held, out_ready=1 -> out_src sequence 0,1,2,...,7,0, one byte per cycle with no bubbles.
- Burst, BURST=4: req=0x05 held -> out_src 0,0,0,0,2,2,2,2,0. Drop req[0] after its 2nd grant -> lane 2 wins on the next grant.
- Backpressure: out_valid=1, out_data=0x3C, out_ready=0 for 5 cycles while req toggles -> out_data stays 0x3C, gnt=0, ptr unchanged. Raise out_ready with req=0x10 -> drain and load lane 4 in the same cycle.
- Drain to empty: FULL, out_ready=1, req=0x00 -> out_valid=0 next cycle and out_data holds. A later req=0x80 -> out_src=7 one cycle after the request.
